// File: rtl/bandai_boot_handshake_if.sv
// Bandai boot handshake bus bundle.
//
// Groups the handshake signals between the console boot controller, the
// cartridge mapper and the boot handshake engine.
//   start_i  begin handshake request
//   so_i     mapper serial out (idles high)
//   addr_o   cartridge address byte driven by the engine
//   busy_o   handshake in progress
//   done_o   handshake finished, result valid
//   pass_o   done with no error
//   err_o    0 ok, 1 timeout, 2 payload mismatch, 3 stop-bit error
//   data_o   captured 16-bit payload
// Modport slave is the engine side; master is the boot controller / mapper side.
interface bandai_boot_handshake_if;
  logic        start_i;
  logic        so_i;
  logic [7:0]  addr_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [1:0]  err_o;
  logic [15:0] data_o;

  modport slave (
    input  start_i, so_i,
    output addr_o, busy_o, done_o, pass_o, err_o, data_o
  );

  modport master (
    output start_i, so_i,
    input  addr_o, busy_o, done_o, pass_o, err_o, data_o
  );
endinterface

// File: rtl/bandai_boot_handshake.sv
// Bandai boot handshake engine (console side).
//
// On start, drives the unlock sequence 5Ah then A5h onto the cartridge
// address pins, hunts for the start bit of the 18-bit mapper frame on so_i,
// deserialises the 16-bit LSB-first payload, checks the stop bit and the
// payload, and reports the result until the next start or reset.
//
// Ports:
//   clk  system clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  bandai_boot_handshake_if.slave (start_i, so_i in; addr_o, busy_o,
//        done_o, pass_o, err_o, data_o out)
//
// Configuration macro SO_SYNC2_EN: when defined, so_i passes through a
// 2-flop synchroniser (reset to 1) before the HUNT/DATA logic, adding two
// edges of latency. The timeout window is still counted in HUNT cycles.
module bandai_boot_handshake #(
  parameter logic [15:0] EXPECTED  = 16'h28A0,
  parameter logic [7:0]  IDLE_ADDR = 8'h00,
  parameter int          MAX_WAIT  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  bandai_boot_handshake_if.slave     bus
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);
  localparam logic [7:0] ACK_ADDR = 8'h5A;
  localparam logic [7:0] NAK_ADDR = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_NAK, S_HUNT, S_DATA, S_STOP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        so_bit;
  logic        so_s;

  // Anything other than a clean 0 (including X/Z from a cartridge held in
  // reset) counts as 1, i.e. "no start bit".
  always_comb begin
    so_bit = 1'b1;
    if (bus.so_i == 1'b0) so_bit = 1'b0;
  end

`ifdef SO_SYNC2_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], so_bit};
  end
  assign so_s = sync_q[1];
`else
  assign so_s = so_bit;
`endif

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bit_d   = bit_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
          state_d = S_ACK;
          data_d  = 16'h0000;
          err_d   = 2'd0;
        end
      end
      S_ACK: state_d = S_NAK;
      S_NAK: begin
        state_d = S_HUNT;
        wait_d  = 8'd0;
      end
      S_HUNT: begin
        if (!so_s) begin
          state_d = S_DATA;
          bit_d   = 5'd0;
        end else if (wait_q >= WAIT_LIM) begin
          state_d = S_DONE;
          err_d   = 2'd1;
        end else if (wait_q != 8'hFF) begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DATA: begin
        // LSB-first frame: each new bit enters at the top and shifts down.
        data_d = {so_s, data_q[15:1]};
        if (bit_q < 5'd16) bit_d = bit_q + 5'd1;
        if (bit_q == 5'd15) state_d = S_STOP;
      end
      S_STOP: begin
        state_d = S_DONE;
        // Stop-bit error takes priority over payload mismatch.
        if (so_s)                     err_d = 2'd3;
        else if (data_q != EXPECTED)  err_d = 2'd2;
        else                          err_d = 2'd0;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    addr_d = IDLE_ADDR;
    if (state_d == S_ACK) addr_d = ACK_ADDR;
    if (state_d == S_NAK) addr_d = NAK_ADDR;
    busy_d = (state_d == S_ACK) || (state_d == S_NAK) || (state_d == S_HUNT) ||
             (state_d == S_DATA) || (state_d == S_STOP);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
      bit_q   <= 5'd0;
      data_q  <= 16'h0000;
      err_q   <= 2'd0;
      addr_q  <= IDLE_ADDR;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.addr_o = addr_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.pass_o = pass_q;
  assign bus.err_o  = err_q;
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_bandai_boot_handshake.sv
module tb_bandai_boot_handshake;

`ifdef SO_SYNC2_EN
  localparam int LAT = 22;
`else
  localparam int LAT = 20;
`endif
  localparam int MAX_WAIT = 32;
  localparam int TO_LAT   = MAX_WAIT + 3;

  typedef struct {
    logic [1:0]  err;
    logic        pass;
    logic [15:0] data;
    int          lat;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  bandai_boot_handshake_if dif ();

  bandai_boot_handshake #(
    .EXPECTED (16'h28A0),
    .IDLE_ADDR(8'h00),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  always #5 clk = ~clk;

  // Ideal mapper: after seeing A5h on the address pins it shifts out the
  // 18-bit frame (bit 0 first) one bit per clock, then idles high.
  logic [17:0] map_frame = 18'h3FFFF;
  logic        map_en    = 1'b0;
  int          map_idx   = 0;
  logic        map_act   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      map_act  <= 1'b0;
      map_idx  <= 0;
      dif.so_i <= 1'b1;
    end else if (map_en && dif.addr_o == 8'hA5) begin
      dif.so_i <= map_frame[0];
      map_idx  <= 1;
      map_act  <= 1'b1;
    end else if (map_act) begin
      if (map_idx < 18) dif.so_i <= map_frame[map_idx];
      else begin
        dif.so_i <= 1'b1;
        map_act  <= 1'b0;
      end
      map_idx <= map_idx + 1;
    end else begin
      dif.so_i <= 1'b1;
    end
  end

  function automatic logic [17:0] mk(input logic [15:0] p, input logic stop);
    return {stop, p, 1'b0};
  endfunction

  // Pulse START so it is sampled at "edge 0"; returns #1 after edge 0.
  task automatic launch(input logic [17:0] frame, input logic use_map);
    map_frame   = frame;
    map_en      = use_map;
    dif.start_i = 1'b1;
    @(posedge clk); #1;
    dif.start_i = 1'b0;
  endtask

  // Step edges until DONE is seen; lat = index of the edge after which DONE is visible.
  task automatic wait_done(input int start_n, output int lat);
    int n;
    n = start_n;
    while (!dif.done_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dif.start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (dif.addr_o !== 8'h00) begin n_miss++; $display("FAIL reset_addr got=%h want=00", dif.addr_o); end
    n_vec++; if (dif.busy_o !== 1'b0) begin n_miss++; $display("FAIL reset_busy got=%b want=0", dif.busy_o); end
    n_vec++; if (dif.done_o !== 1'b0) begin n_miss++; $display("FAIL reset_done got=%b want=0", dif.done_o); end
    n_vec++; if (dif.pass_o !== 1'b0) begin n_miss++; $display("FAIL reset_pass got=%b want=0", dif.pass_o); end
    n_vec++; if (dif.err_o !== 2'd0) begin n_miss++; $display("FAIL reset_err got=%0d want=0", dif.err_o); end
    n_vec++; if (dif.data_o !== 16'h0) begin n_miss++; $display("FAIL reset_data got=%h want=0000", dif.data_o); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_pass;
    int lat;
    exp_t e;
    sb.push_back('{err: 2'd0, pass: 1'b1, data: 16'h28A0, lat: LAT});
    launch(mk(16'h28A0, 1'b0), 1'b1);
    n_vec++; if (dif.addr_o !== 8'h5A) begin n_miss++; $display("FAIL pass_ack_addr got=%h want=5a", dif.addr_o); end
    n_vec++; if (dif.busy_o !== 1'b1) begin n_miss++; $display("FAIL pass_busy got=%b want=1", dif.busy_o); end
    @(posedge clk); #1;
    n_vec++; if (dif.addr_o !== 8'hA5) begin n_miss++; $display("FAIL pass_nak_addr got=%h want=a5", dif.addr_o); end
    @(posedge clk); #1;
    n_vec++; if (dif.addr_o !== 8'h00) begin n_miss++; $display("FAIL pass_hunt_addr got=%h want=00", dif.addr_o); end
    wait_done(2, lat);
    e = sb.pop_front();
    n_vec++; if (lat !== e.lat) begin n_miss++; $display("FAIL pass_latency got=%0d want=%0d", lat, e.lat); end
    n_vec++; if (dif.pass_o !== e.pass) begin n_miss++; $display("FAIL pass_pass got=%b want=%b", dif.pass_o, e.pass); end
    n_vec++; if (dif.err_o !== e.err) begin n_miss++; $display("FAIL pass_err got=%0d want=%0d", dif.err_o, e.err); end
    n_vec++; if (dif.data_o !== e.data) begin n_miss++; $display("FAIL pass_data got=%h want=%h", dif.data_o, e.data); end
    n_vec++; if (dif.busy_o !== 1'b0) begin n_miss++; $display("FAIL pass_busy_done got=%b want=0", dif.busy_o); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (dif.done_o !== 1'b1) begin n_miss++; $display("FAIL pass_done_hold got=%b want=1", dif.done_o); end
    n_vec++; if (dif.data_o !== e.data) begin n_miss++; $display("FAIL pass_data_hold got=%h want=%h", dif.data_o, e.data); end
  endtask

  task automatic test_mismatch;
    int lat;
    exp_t e;
    sb.push_back('{err: 2'd2, pass: 1'b0, data: 16'h28A1, lat: LAT});
    launch(mk(16'h28A1, 1'b0), 1'b1);
    wait_done(0, lat);
    e = sb.pop_front();
    n_vec++; if (lat !== e.lat) begin n_miss++; $display("FAIL mism_latency got=%0d want=%0d", lat, e.lat); end
    n_vec++; if (dif.done_o !== 1'b1) begin n_miss++; $display("FAIL mism_done got=%b want=1", dif.done_o); end
    n_vec++; if (dif.pass_o !== e.pass) begin n_miss++; $display("FAIL mism_pass got=%b want=%b", dif.pass_o, e.pass); end
    n_vec++; if (dif.err_o !== e.err) begin n_miss++; $display("FAIL mism_err got=%0d want=%0d", dif.err_o, e.err); end
    n_vec++; if (dif.data_o !== e.data) begin n_miss++; $display("FAIL mism_data got=%h want=%h", dif.data_o, e.data); end
  endtask

  task automatic test_stop_err;
    int lat;
    exp_t e;
    sb.push_back('{err: 2'd3, pass: 1'b0, data: 16'h28A0, lat: LAT});
    launch(mk(16'h28A0, 1'b1), 1'b1);
    wait_done(0, lat);
    e = sb.pop_front();
    n_vec++; if (lat !== e.lat) begin n_miss++; $display("FAIL stop_latency got=%0d want=%0d", lat, e.lat); end
    n_vec++; if (dif.pass_o !== e.pass) begin n_miss++; $display("FAIL stop_pass got=%b want=%b", dif.pass_o, e.pass); end
    n_vec++; if (dif.err_o !== e.err) begin n_miss++; $display("FAIL stop_err got=%0d want=%0d", dif.err_o, e.err); end
    n_vec++; if (dif.data_o !== e.data) begin n_miss++; $display("FAIL stop_data got=%h want=%h", dif.data_o, e.data); end
  endtask

  task automatic test_timeout;
    int lat;
    exp_t e;
    sb.push_back('{err: 2'd1, pass: 1'b0, data: 16'h0000, lat: TO_LAT});
    launch(18'h3FFFF, 1'b0);
    wait_done(0, lat);
    e = sb.pop_front();
    n_vec++; if (lat !== e.lat) begin n_miss++; $display("FAIL tmo_latency got=%0d want=%0d", lat, e.lat); end
    n_vec++; if (dif.done_o !== 1'b1) begin n_miss++; $display("FAIL tmo_done got=%b want=1", dif.done_o); end
    n_vec++; if (dif.pass_o !== e.pass) begin n_miss++; $display("FAIL tmo_pass got=%b want=%b", dif.pass_o, e.pass); end
    n_vec++; if (dif.err_o !== e.err) begin n_miss++; $display("FAIL tmo_err got=%0d want=%0d", dif.err_o, e.err); end
    n_vec++; if (dif.data_o !== e.data) begin n_miss++; $display("FAIL tmo_data got=%h want=%h", dif.data_o, e.data); end
  endtask

  task automatic test_rst_abort;
    int lat;
    exp_t e;
    launch(mk(16'h28A0, 1'b0), 1'b1);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (dif.addr_o !== 8'h00) begin n_miss++; $display("FAIL abort_addr got=%h want=00", dif.addr_o); end
    n_vec++; if (dif.busy_o !== 1'b0) begin n_miss++; $display("FAIL abort_busy got=%b want=0", dif.busy_o); end
    n_vec++; if (dif.done_o !== 1'b0) begin n_miss++; $display("FAIL abort_done got=%b want=0", dif.done_o); end
    n_vec++; if (dif.err_o !== 2'd0) begin n_miss++; $display("FAIL abort_err got=%0d want=0", dif.err_o); end
    n_vec++; if (dif.data_o !== 16'h0) begin n_miss++; $display("FAIL abort_data got=%h want=0000", dif.data_o); end
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (dif.busy_o !== 1'b0) begin n_miss++; $display("FAIL abort_stays_idle got=%b want=0", dif.busy_o); end
    sb.push_back('{err: 2'd0, pass: 1'b1, data: 16'h28A0, lat: LAT});
    launch(mk(16'h28A0, 1'b0), 1'b1);
    wait_done(0, lat);
    e = sb.pop_front();
    n_vec++; if (lat !== e.lat) begin n_miss++; $display("FAIL abort_re_latency got=%0d want=%0d", lat, e.lat); end
    n_vec++; if (dif.pass_o !== e.pass) begin n_miss++; $display("FAIL abort_re_pass got=%b want=%b", dif.pass_o, e.pass); end
    n_vec++; if (dif.data_o !== e.data) begin n_miss++; $display("FAIL abort_re_data got=%h want=%h", dif.data_o, e.data); end
  endtask

  task automatic test_back_to_back;
    int n;
    int lat;
    exp_t e;
    sb.push_back('{err: 2'd2, pass: 1'b0, data: 16'h1234, lat: LAT});
    launch(mk(16'h1234, 1'b0), 1'b1);
    n = 0;
    while (!dif.done_o && n < 200) begin
      dif.start_i = (n == 5) || (n == 11);
      @(posedge clk); #1;
      n++;
    end
    dif.start_i = 1'b0;
    e = sb.pop_front();
    n_vec++; if (n !== e.lat) begin n_miss++; $display("FAIL b2b_latency got=%0d want=%0d", n, e.lat); end
    n_vec++; if (dif.err_o !== e.err) begin n_miss++; $display("FAIL b2b_err got=%0d want=%0d", dif.err_o, e.err); end
    n_vec++; if (dif.data_o !== e.data) begin n_miss++; $display("FAIL b2b_data got=%h want=%h", dif.data_o, e.data); end
    repeat (4) @(posedge clk);
    #1;
    n_vec++; if (dif.done_o !== 1'b1) begin n_miss++; $display("FAIL b2b_single_done got=%b want=1", dif.done_o); end
    n_vec++; if (dif.busy_o !== 1'b0) begin n_miss++; $display("FAIL b2b_single_busy got=%b want=0", dif.busy_o); end
    sb.push_back('{err: 2'd0, pass: 1'b1, data: 16'h28A0, lat: LAT});
    launch(mk(16'h28A0, 1'b0), 1'b1);
    n_vec++; if (dif.addr_o !== 8'h5A) begin n_miss++; $display("FAIL b2b_restart_addr got=%h want=5a", dif.addr_o); end
    n_vec++; if (dif.done_o !== 1'b0) begin n_miss++; $display("FAIL b2b_restart_done got=%b want=0", dif.done_o); end
    n_vec++; if (dif.data_o !== 16'h0) begin n_miss++; $display("FAIL b2b_restart_data got=%h want=0000", dif.data_o); end
    n_vec++; if (dif.err_o !== 2'd0) begin n_miss++; $display("FAIL b2b_restart_err got=%0d want=0", dif.err_o); end
    wait_done(0, lat);
    e = sb.pop_front();
    n_vec++; if (lat !== e.lat) begin n_miss++; $display("FAIL b2b_re_latency got=%0d want=%0d", lat, e.lat); end
    n_vec++; if (dif.pass_o !== e.pass) begin n_miss++; $display("FAIL b2b_re_pass got=%b want=%b", dif.pass_o, e.pass); end
    n_vec++; if (dif.data_o !== e.data) begin n_miss++; $display("FAIL b2b_re_data got=%h want=%h", dif.data_o, e.data); end
  endtask

  initial begin
    dif.start_i = 1'b0;
    test_reset();
    test_pass();
    test_mismatch();
    test_stop_err();
    test_timeout();
    test_rst_abort();
    test_back_to_back();
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_empty got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
